// File: rtl/te_pwr_seq_pkg.sv
// te_seq_pkg: shared types and constants for the TimingEngine power/isolation
// sequencer (te_pwr_seq).
//   te_seq_state_e : sequencer FSM states
//   TE_SEQ_*_DEF   : default SETTLE_CYC / PLL_TIMEOUT values
//   iso_entry()    : ISO_* state that unwinds a partially completed REL_* step
package te_seq_pkg;

    typedef enum logic [3:0] {
        ST_OFF,
        ST_REL_M1,
        ST_REL_M3,
        ST_REL_M2,
        ST_WAIT_PLL,
        ST_ON,
        ST_RX,
        ST_ISO_M2,
        ST_ISO_M3,
        ST_ISO_M1
    } te_seq_state_e;

    localparam int unsigned TE_SEQ_SETTLE_CYC_DEF  = 4;
    localparam int unsigned TE_SEQ_PLL_TIMEOUT_DEF = 200;

    // Abort from a release step starts isolating at the highest domain that
    // step released, so domains are always re-isolated in reverse power order.
    function automatic te_seq_state_e iso_entry(input te_seq_state_e rel);
        case (rel)
            ST_REL_M1: return ST_ISO_M1;
            ST_REL_M3: return ST_ISO_M3;
            default:   return ST_ISO_M2;
        endcase
    endfunction

endpackage

// File: rtl/te_pwr_seq_if.sv
// te_pwr_seq_if: request/status bundle between the TimingEngine controller
// (master) and the power/isolation sequencer (slave).
//   master drives : req_on, req_rx, pll_settled, tarst_fs
//   slave drives  : isolate_m1/m3/m2, radio_enable, radio_rx_en, busy, timeout_err
interface te_pwr_seq_if;
    logic req_on;
    logic req_rx;
    logic pll_settled;
    logic tarst_fs;
    logic isolate_m1;
    logic isolate_m3;
    logic isolate_m2;
    logic radio_enable;
    logic radio_rx_en;
    logic busy;
    logic timeout_err;

    modport master (
        output req_on, req_rx, pll_settled, tarst_fs,
        input  isolate_m1, isolate_m3, isolate_m2,
        input  radio_enable, radio_rx_en, busy, timeout_err
    );

    modport slave (
        input  req_on, req_rx, pll_settled, tarst_fs,
        output isolate_m1, isolate_m3, isolate_m2,
        output radio_enable, radio_rx_en, busy, timeout_err
    );
endinterface

// File: rtl/te_seq_step_timer.sv
// te_seq_step_timer: loadable saturating down-counter.
//   ck, arst  : clock, async active-high reset (count -> 0)
//   load      : load load_val this cycle (wins over counting)
//   load_val  : value loaded; done rises after load_val further cycles
//   done      : count has reached zero (stays there, no wrap)
module te_seq_step_timer #(
    parameter int unsigned W = 3
) (
    input  logic         ck,
    input  logic         arst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] cnt;

    always_ff @(posedge ck or posedge arst) begin
        if (arst)             cnt <= '0;
        else if (load)        cnt <= load_val;
        else if (cnt != '0)   cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);
endmodule

// File: rtl/te_pwr_seq.sv
// te_pwr_seq: power/isolation sequencer for the TimingEngine path across
// PD_M1, PD_M3, PD_M2. Releases isolation M1 -> M3 -> M2, waits for PLL lock,
// then enables the radio (and RX on request); powers down in reverse order.
// tarst_fs aborts straight to OFF from any state.
//   ck, arst : clock, async active-high reset
//   bus      : te_pwr_seq_if.slave (requests in, isolation/enable/status out)
// Parameters: SETTLE_CYC (1..255) cycles per isolation step,
//             PLL_TIMEOUT (1..65535) WAIT_PLL cycles before abort.
// Build option: TE_SEQ_PLL_TIMEOUT_EN enables the PLL timeout counter and
// timeout_err; without it WAIT_PLL waits for lock indefinitely.
module te_pwr_seq
    import te_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYC  = TE_SEQ_SETTLE_CYC_DEF,
    parameter int unsigned PLL_TIMEOUT = TE_SEQ_PLL_TIMEOUT_DEF
) (
    input  logic         ck,
    input  logic         arst,
    te_pwr_seq_if.slave  bus
);
    localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
    localparam logic [SW-1:0] STEP_LD = SW'(SETTLE_CYC - 1);

    te_seq_state_e state, state_n;
    logic          drop_q, drop;
    logic          step_done, pll_to, enter;
    logic          iso_m1_q, iso_m3_q, iso_m2_q, ren_q, rxen_q, busy_q;
    logic          iso_m1_n, iso_m3_n, iso_m2_n, ren_n, rxen_n, busy_n;
    logic          err_set;

    // Every state change reloads both timers, so each state starts a fresh count.
    assign enter = (state_n != state);

    te_seq_step_timer #(.W(SW)) u_step (
        .ck       (ck),
        .arst     (arst),
        .load     (enter),
        .load_val (STEP_LD),
        .done     (step_done)
    );

`ifdef TE_SEQ_PLL_TIMEOUT_EN
    localparam int unsigned TW = $clog2(PLL_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LD = TW'(PLL_TIMEOUT - 1);
    logic to_done;
    logic err_q;

    te_seq_step_timer #(.W(TW)) u_pll_to (
        .ck       (ck),
        .arst     (arst),
        .load     (enter),
        .load_val (TO_LD),
        .done     (to_done)
    );

    assign pll_to = to_done;

    // Sticky; only an idle OFF with no pending request clears it.
    always_ff @(posedge ck or posedge arst) begin
        if (arst)                                 err_q <= 1'b0;
        else if (err_set)                         err_q <= 1'b1;
        else if (state == ST_OFF && !bus.req_on)  err_q <= 1'b0;
    end

    assign bus.timeout_err = err_q;
`else
    // PLL_TIMEOUT is at least 1, so this never fires: WAIT_PLL waits for lock.
    assign pll_to          = (PLL_TIMEOUT == 0);
    assign bus.timeout_err = 1'b0;
`endif

    always_comb begin
        state_n = state;
        err_set = 1'b0;
        // A drop anywhere inside a release step is remembered until the step ends.
        drop    = drop_q | ~bus.req_on;

        if (bus.tarst_fs) begin
            state_n = ST_OFF;
        end else begin
            case (state)
                ST_OFF:      if (bus.req_on) state_n = ST_REL_M1;
                ST_REL_M1:   if (step_done) state_n = drop ? iso_entry(state) : ST_REL_M3;
                ST_REL_M3:   if (step_done) state_n = drop ? iso_entry(state) : ST_REL_M2;
                ST_REL_M2:   if (step_done) state_n = drop ? iso_entry(state) : ST_WAIT_PLL;
                ST_WAIT_PLL: begin
                    if (!bus.req_on)          state_n = ST_ISO_M2;
                    else if (bus.pll_settled) state_n = ST_ON;
                    else if (pll_to) begin
                        state_n = ST_ISO_M2;
                        err_set = 1'b1;
                    end
                end
                ST_ON: begin
                    if (!bus.req_on)           state_n = ST_ISO_M2;
                    else if (!bus.pll_settled) state_n = ST_WAIT_PLL;
                    else if (bus.req_rx)       state_n = ST_RX;
                end
                ST_RX: begin
                    if (!bus.req_on)           state_n = ST_ISO_M2;
                    else if (!bus.pll_settled) state_n = ST_WAIT_PLL;
                    else if (!bus.req_rx)      state_n = ST_ON;
                end
                ST_ISO_M2:   if (step_done) state_n = ST_ISO_M3;
                ST_ISO_M3:   if (step_done) state_n = ST_ISO_M1;
                ST_ISO_M1:   if (step_done) state_n = ST_OFF;
                default:     state_n = ST_OFF;
            endcase
        end

        // Outputs are a decode of the next state, registered alongside it.
        // Aborted release paths only pass through ISO states whose lower
        // domains are already isolated, so the decode holds for them too.
        iso_m1_n = !(state_n inside {ST_REL_M1, ST_REL_M3, ST_REL_M2, ST_WAIT_PLL,
                                     ST_ON, ST_RX, ST_ISO_M2, ST_ISO_M3});
        iso_m3_n = !(state_n inside {ST_REL_M3, ST_REL_M2, ST_WAIT_PLL,
                                     ST_ON, ST_RX, ST_ISO_M2});
        iso_m2_n = !(state_n inside {ST_REL_M2, ST_WAIT_PLL, ST_ON, ST_RX});
        ren_n    = (state_n inside {ST_ON, ST_RX});
        rxen_n   = (state_n == ST_RX);
        busy_n   = !(state_n inside {ST_OFF, ST_ON, ST_RX});
    end

    always_ff @(posedge ck or posedge arst) begin
        if (arst) begin
            state    <= ST_OFF;
            drop_q   <= 1'b0;
            iso_m1_q <= 1'b1;
            iso_m3_q <= 1'b1;
            iso_m2_q <= 1'b1;
            ren_q    <= 1'b0;
            rxen_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            drop_q   <= enter ? 1'b0 : drop;
            iso_m1_q <= iso_m1_n;
            iso_m3_q <= iso_m3_n;
            iso_m2_q <= iso_m2_n;
            ren_q    <= ren_n;
            rxen_q   <= rxen_n;
            busy_q   <= busy_n;
        end
    end

    assign bus.isolate_m1   = iso_m1_q;
    assign bus.isolate_m3   = iso_m3_q;
    assign bus.isolate_m2   = iso_m2_q;
    assign bus.radio_enable = ren_q;
    assign bus.radio_rx_en  = rxen_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_te_pwr_seq.sv
// tb_te_pwr_seq: directed bench for te_pwr_seq (SETTLE_CYC=4, PLL_TIMEOUT=10).
// Expected output vectors are queued as each cycle is driven and compared
// after the following rising edge. Timeout checks depend on
// TE_SEQ_PLL_TIMEOUT_EN being defined for the build.
module tb_te_pwr_seq;
    logic ck = 1'b0;
    logic ck_en = 1'b1;
    logic arst = 1'b0;

    te_pwr_seq_if bus();

    te_pwr_seq #(.SETTLE_CYC(4), .PLL_TIMEOUT(10)) u_dut (
        .ck   (ck),
        .arst (arst),
        .bus  (bus)
    );

    always #5 if (ck_en) ck = ~ck;

    typedef struct {
        string      tag;
        logic [6:0] exp;
    } sb_t;

    sb_t   sbq[$];
    int    ncmp = 0;
    int    nerr = 0;
    string phase = "init";

    // {isolate_m1, isolate_m3, isolate_m2, radio_enable, radio_rx_en, busy, timeout_err}
    function automatic logic [6:0] v(input string st, input bit err);
        logic [2:0] iso;
        logic       re, rx, b;
        iso = 3'b111; re = 1'b0; rx = 1'b0; b = 1'b1;
        case (st)
            "OFF":    b = 1'b0;
            "REL_M1": iso = 3'b011;
            "REL_M3": iso = 3'b001;
            "REL_M2": iso = 3'b000;
            "WAIT":   iso = 3'b000;
            "ON":     begin iso = 3'b000; re = 1'b1; b = 1'b0; end
            "RX":     begin iso = 3'b000; re = 1'b1; rx = 1'b1; b = 1'b0; end
            "ISO_M2": iso = 3'b001;
            "ISO_M3": iso = 3'b011;
            "ISO_M1": iso = 3'b111;
            default:  iso = 3'bxxx;
        endcase
        return {iso, re, rx, b, err};
    endfunction

    task automatic check_now();
        sb_t        e;
        logic [6:0] obs;
        e   = sbq.pop_front();
        obs = {bus.isolate_m1, bus.isolate_m3, bus.isolate_m2,
               bus.radio_enable, bus.radio_rx_en, bus.busy, bus.timeout_err};
        ncmp++;
        assert (obs === e.exp) else begin
            nerr++;
            $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
        end
    endtask

    task automatic expect_st(input string st, input bit err, input int n);
        for (int i = 0; i < n; i++) begin
            sbq.push_back('{$sformatf("%s:%s#%0d", phase, st, i), v(st, err)});
            @(posedge ck);
            #1;
            check_now();
        end
    endtask

    task automatic expect_async(input string tag);
        sbq.push_back('{tag, v("OFF", 1'b0)});
        check_now();
    endtask

    initial begin
        bus.req_on      = 1'b0;
        bus.req_rx      = 1'b0;
        bus.pll_settled = 1'b0;
        bus.tarst_fs    = 1'b0;

        phase = "reset";
        #2 arst = 1'b1;
        #1 expect_async("reset:async");
        @(posedge ck); #1;
        arst = 1'b0;
        expect_st("OFF", 0, 2);

        // Power-up: +1/+5/+9 isolation releases, WAIT_PLL from +13, lock at +21.
        phase = "up";
        bus.req_on = 1'b1;
        expect_st("REL_M1", 0, 4);
        expect_st("REL_M3", 0, 4);
        expect_st("REL_M2", 0, 4);
        expect_st("WAIT", 0, 8);
        bus.pll_settled = 1'b1;
        expect_st("ON", 0, 2);

        phase = "rx";
        bus.req_rx = 1'b1;
        expect_st("RX", 0, 2);
        bus.req_rx = 1'b0;
        expect_st("ON", 0, 2);

        // Power-down; req_on re-raised mid-ISO is ignored until OFF.
        phase = "down";
        bus.req_on = 1'b0;
        expect_st("ISO_M2", 0, 4);
        expect_st("ISO_M3", 0, 2);
        bus.req_on = 1'b1;
        expect_st("ISO_M3", 0, 2);
        expect_st("ISO_M1", 0, 4);
        expect_st("OFF", 0, 1);
        expect_st("REL_M1", 0, 4);
        expect_st("REL_M3", 0, 2);

        phase = "fs_rel";
        bus.tarst_fs = 1'b1;
        expect_st("OFF", 0, 2);
        bus.tarst_fs = 1'b0;
        expect_st("REL_M1", 0, 4);
        expect_st("REL_M3", 0, 2);

        // Drop in REL_M3: step completes, then M3 and M1 re-isolate; M2 stays isolated.
        phase = "drop_rel";
        bus.req_on = 1'b0;
        expect_st("REL_M3", 0, 2);
        expect_st("ISO_M3", 0, 4);
        expect_st("ISO_M1", 0, 4);
        expect_st("OFF", 0, 2);

        phase = "fs_rx";
        bus.req_on = 1'b1;
        expect_st("REL_M1", 0, 4);
        expect_st("REL_M3", 0, 4);
        expect_st("REL_M2", 0, 4);
        expect_st("WAIT", 0, 1);
        expect_st("ON", 0, 1);
        bus.req_rx = 1'b1;
        expect_st("RX", 0, 2);
        bus.tarst_fs = 1'b1;
        expect_st("OFF", 0, 1);
        bus.tarst_fs    = 1'b0;
        bus.req_rx      = 1'b0;
        bus.pll_settled = 1'b0;
        expect_st("REL_M1", 0, 4);
        expect_st("REL_M3", 0, 4);
        expect_st("REL_M2", 0, 4);

        phase = "pll";
`ifdef TE_SEQ_PLL_TIMEOUT_EN
        expect_st("WAIT", 0, 10);
        expect_st("ISO_M2", 1, 1);
        bus.req_on = 1'b0;
        expect_st("ISO_M2", 1, 3);
        expect_st("ISO_M3", 1, 4);
        expect_st("ISO_M1", 1, 4);
        expect_st("OFF", 1, 1);
        expect_st("OFF", 0, 1);
        bus.req_on = 1'b1;
        expect_st("REL_M1", 0, 4);
        expect_st("REL_M3", 0, 4);
        expect_st("REL_M2", 0, 4);
        expect_st("WAIT", 0, 3);
`else
        expect_st("WAIT", 0, 15);
`endif
        bus.pll_settled = 1'b1;
        expect_st("ON", 0, 2);
        // Lock loss returns to WAIT_PLL with a fresh timeout budget.
        bus.pll_settled = 1'b0;
        expect_st("WAIT", 0, 8);
        bus.pll_settled = 1'b1;
        expect_st("ON", 0, 1);
        bus.pll_settled = 1'b0;
        expect_st("WAIT", 0, 2);

        // Async reset with the clock stopped.
        phase = "arst";
        ck_en = 1'b0;
        #3 arst = 1'b1;
        #1 expect_async("arst:immediate");
        #20 expect_async("arst:held");
        bus.req_on = 1'b0;
        arst  = 1'b0;
        ck_en = 1'b1;
        expect_st("OFF", 0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
